// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage boundary.
//
// Both sides of the stage live in the same bundle so a single instance
// describes one stage register and its neighbours:
//   in_valid / in_ready / in_data    upstream side of the stage
//   out_valid / out_ready / out_data downstream side of the stage
//   flush                            synchronous squash request
//   occupancy                        number of payloads held (0..2)
//
// Modports:
//   slave  - the stage register itself
//   master - whatever drives and consumes the stage (hazard unit, bench)
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush
// and an optional skid entry.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - pipe_stage_reg_if.slave: in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, flush, occupancy
//
// Handshake: a payload moves across a port on a rising edge where that
// port's valid and ready are both 1. valid never waits for ready, and a
// payload offered with valid=1 is held stable by its sender until taken.
//
// out_data always reflects the main entry. With SKID=1 a second (skid)
// entry absorbs the one payload that can arrive in the cycle after the
// main entry stalls, which lets in_ready come straight from a flop.
// With SKID=0 in_ready is the classic !out_valid || out_ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               SKID      = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  localparam bit HAS_SKID = (SKID != 0);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic main_free;
  logic skid_load;

  generate
    if (HAS_SKID) begin : g_skid_ready
      // Registered ready: only the skid flag, never out_ready.
      assign in_ready = !skid_valid;
    end else begin : g_pass_ready
      assign in_ready = !main_valid || bus.out_ready;
    end
  endgenerate

  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = main_valid && bus.out_ready;
  // Main entry can take a new value at this edge.
  assign main_free = !main_valid || out_fire;
  // New data goes to skid whenever main cannot take it directly, either
  // because main is stalled or because the older skid payload claims main.
  assign skid_load = HAS_SKID && in_fire && (!main_free || skid_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      main_data  <= FLUSH_VAL;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= bus.in_data;
      end else begin
        // Drained: data bits stay put so an idle stage does not toggle.
        main_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      skid_valid <= 1'b0;
    end else if (skid_load) begin
      skid_valid <= 1'b1;
    end else if (main_free) begin
      skid_valid <= 1'b0;
    end
  end

  // Skid payload is only meaningful while skid_valid is set, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [31:0] RV32 = 32'h1357_9BDF;
  localparam logic [31:0] FV32 = 32'h2468_ACE0;
  localparam logic [7:0]  RV8  = 8'h3C;
  localparam logic [7:0]  FV8  = 8'hC3;
  localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FV64 = 64'hFEDC_BA98_7654_3210;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  // 0: W32 skid, 1: W32 no skid, 2: W8 skid, 3: W64 skid
  pipe_stage_reg_if #(.WIDTH(32)) if0 ();
  pipe_stage_reg_if #(.WIDTH(32)) if1 ();
  pipe_stage_reg_if #(.WIDTH(8))  if2 ();
  pipe_stage_reg_if #(.WIDTH(64)) if3 ();

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV32), .FLUSH_VAL(FV32), .SKID(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV32), .FLUSH_VAL(FV32), .SKID(0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_stage_reg #(.WIDTH(8), .RESET_VAL(RV8), .FLUSH_VAL(FV8), .SKID(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV64), .FLUSH_VAL(FV64), .SKID(1))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  int          sel = 0;
  logic        drv_iv = 1'b0;
  logic [63:0] drv_id = '0;
  logic        drv_ordy = 1'b0;
  logic        drv_fl = 1'b0;

  assign if0.in_valid  = (sel == 0) && drv_iv;
  assign if0.in_data   = drv_id[31:0];
  assign if0.out_ready = (sel == 0) && drv_ordy;
  assign if0.flush     = (sel == 0) && drv_fl;
  assign if1.in_valid  = (sel == 1) && drv_iv;
  assign if1.in_data   = drv_id[31:0];
  assign if1.out_ready = (sel == 1) && drv_ordy;
  assign if1.flush     = (sel == 1) && drv_fl;
  assign if2.in_valid  = (sel == 2) && drv_iv;
  assign if2.in_data   = drv_id[7:0];
  assign if2.out_ready = (sel == 2) && drv_ordy;
  assign if2.flush     = (sel == 2) && drv_fl;
  assign if3.in_valid  = (sel == 3) && drv_iv;
  assign if3.in_data   = drv_id;
  assign if3.out_ready = (sel == 3) && drv_ordy;
  assign if3.flush     = (sel == 3) && drv_fl;

  logic        obs_ir, obs_ov;
  logic [63:0] obs_od;
  logic [1:0]  obs_occ;

  always_comb begin
    obs_ir  = 1'b0;
    obs_ov  = 1'b0;
    obs_od  = '0;
    obs_occ = '0;
    case (sel)
      0: begin obs_ir = if0.in_ready; obs_ov = if0.out_valid; obs_od = 64'(if0.out_data); obs_occ = if0.occupancy; end
      1: begin obs_ir = if1.in_ready; obs_ov = if1.out_valid; obs_od = 64'(if1.out_data); obs_occ = if1.occupancy; end
      2: begin obs_ir = if2.in_ready; obs_ov = if2.out_valid; obs_od = 64'(if2.out_data); obs_occ = if2.occupancy; end
      default: begin obs_ir = if3.in_ready; obs_ov = if3.out_valid; obs_od = if3.out_data; obs_occ = if3.occupancy; end
    endcase
  end

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds payloads the stage owes downstream, oldest first.
  // shown is what out_data must display.
  logic [63:0] exp_q[$];
  logic [63:0] shown;
  logic [63:0] mask;
  logic [63:0] m_rval, m_fval;
  bit          m_skid;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", tag, sel, $time, obs, exp);
    end
  endtask

  function automatic bit exp_in_ready(input bit ordy);
    if (m_skid) return exp_q.size() < 2;
    return (exp_q.size() == 0) || ordy;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst    = 1'b1;
    drv_iv = 1'b0; drv_ordy = 1'b0; drv_fl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    shown = m_rval;
  endtask

  task automatic select(input int s);
    sel = s;
    case (s)
      0: begin m_skid = 1; mask = 64'h0000_0000_FFFF_FFFF; m_rval = 64'(RV32); m_fval = 64'(FV32); end
      1: begin m_skid = 0; mask = 64'h0000_0000_FFFF_FFFF; m_rval = 64'(RV32); m_fval = 64'(FV32); end
      2: begin m_skid = 1; mask = 64'h0000_0000_0000_00FF; m_rval = 64'(RV8);  m_fval = 64'(FV8);  end
      default: begin m_skid = 1; mask = '1; m_rval = RV64; m_fval = FV64; end
    endcase
    do_reset();
  endtask

  // One clock cycle, entered and left just after a falling edge.
  // acc: model says the input was taken; ofire/oval: DUT output transfer.
  task automatic cycle(input bit iv, input logic [63:0] id, input bit ordy, input bit fl,
                       output bit acc, output bit ofire, output logic [63:0] oval);
    bit er, del;
    drv_iv = iv; drv_id = id; drv_ordy = ordy; drv_fl = fl;
    #1;
    er = exp_in_ready(ordy);
    check_eq("in_ready",  64'(obs_ir),  64'(er));
    check_eq("out_valid", 64'(obs_ov),  64'(exp_q.size() != 0));
    check_eq("out_data",  obs_od,       shown);
    check_eq("occupancy", 64'(obs_occ), 64'(exp_q.size()));
    acc   = iv && er;
    del   = (exp_q.size() != 0) && ordy;
    ofire = obs_ov && ordy && !fl;
    oval  = obs_od;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      shown = m_fval;
    end else begin
      if (del) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(id & mask);
      if (exp_q.size() != 0) shown = exp_q[0];
    end
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  bit          acc, of;
  logic [63:0] ov;
  int          nxt, k;
  bit          c_sent;
  logic [63:0] bp_exp[3];

  initial begin
    select(0);

    // Streaming 1..16 with out_ready held high
    nxt = 1;
    for (int i = 1; i <= 18; i++) begin
      cycle(i <= 16, 64'(i), 1'b1, 1'b0, acc, of, ov);
      if (of) begin
        check_eq("stream_order", ov, 64'(nxt));
        nxt++;
      end
    end
    check_eq("stream_count", 64'(nxt - 1), 64'd16);

    // Backpressure: A held, B in skid, C refused until drain
    bp_exp[0] = 64'hA; bp_exp[1] = 64'hB; bp_exp[2] = 64'hC;
    cycle(1'b1, 64'hA, 1'b0, 1'b0, acc, of, ov);
    cycle(1'b1, 64'hB, 1'b0, 1'b0, acc, of, ov);
    cycle(1'b1, 64'hC, 1'b0, 1'b0, acc, of, ov);
    check_eq("bp_ready_low", 64'(obs_ir), 64'd0);
    check_eq("bp_c_refused", 64'(acc), 64'd0);
    c_sent = 0;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      cycle(!c_sent, 64'hC, 1'b1, 1'b0, acc, of, ov);
      if (!c_sent && acc) c_sent = 1;
      if (of) begin
        if (k < 3) check_eq("bp_order", ov, bp_exp[k]);
        k++;
      end
    end
    check_eq("bp_count", 64'(k), 64'd3);

    // Flush at occupancy 2 with an input offered in the same cycle
    cycle(1'b1, 64'h11, 1'b0, 1'b0, acc, of, ov);
    cycle(1'b1, 64'h22, 1'b0, 1'b0, acc, of, ov);
    check_eq("pre_flush_occ", 64'(obs_occ), 64'd2);
    cycle(1'b1, 64'h55, 1'b0, 1'b1, acc, of, ov);
    check_eq("flush_data", obs_od, 64'(FV32));
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b0, acc, of, ov);
      check_eq("flush_no_leak", 64'(of), 64'd0);
    end

    // Asynchronous reset mid-stream, observed before any clock edge
    cycle(1'b1, 64'hDEAD_BEEF, 1'b0, 1'b0, acc, of, ov);
    cycle(1'b1, 64'h1111_2222, 1'b0, 1'b0, acc, of, ov);
    drv_iv = 1'b0; drv_ordy = 1'b0;
    #1;
    check_eq("mid_occ", 64'(obs_occ), 64'd2);
    check_eq("mid_data", obs_od, 64'hDEAD_BEEF);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 64'(obs_ov), 64'd0);
    check_eq("arst_out_data", obs_od, 64'(RV32));
    check_eq("arst_occupancy", 64'(obs_occ), 64'd0);
    check_eq("arst_in_ready", 64'(obs_ir), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    shown = m_rval;
    for (int j = 0; j < 3; j++) cycle(1'b1, 64'(j + 100), 1'b1, 1'b0, acc, of, ov);

    // No-skid stage with out_ready toggling
    select(1);
    for (int j = 0; j < 16; j++)
      cycle(1'b1, 64'(j + 200), (j % 2) == 0, 1'b0, acc, of, ov);

    // Random valid/ready/flush on no-skid, W8 and W64 stages
    for (int s = 1; s <= 3; s++) begin
      select(s);
      for (int j = 0; j < 300; j++)
        cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
              $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc, of, ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
